// File: rtl/pegasus_pkg.sv
// rtl/pegasus_pkg.sv - shared state encoding and byte-enable constants for the dmem arbiter
package pegasus_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_B0   = 4'b0001;
  localparam logic [3:0] WE_B1   = 4'b0010;
  localparam logic [3:0] WE_B2   = 4'b0100;
  localparam logic [3:0] WE_B3   = 4'b1000;
  localparam logic [3:0] WE_HLO  = 4'b0011;
  localparam logic [3:0] WE_HHI  = 4'b1100;
  localparam logic [3:0] WE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester's request/response bundle toward the dmem arbiter
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          req;
  logic [3:0]    we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_req_check.sv
// rtl/dmem_req_check.sv - flags out-of-range, misaligned and illegal-enable accesses
module dmem_req_check
  import pegasus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  output logic          err
);

  // One extra bit so DEPTH*4 is representable even when it equals 2**AW.
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * 4);

  logic range_err;
  logic mis_err;
  logic en_err;

  always_comb begin
    range_err = ({1'b0, addr} >= LIMIT);
    mis_err   = 1'b0;
    en_err    = 1'b0;
    case (we)
      WE_NONE, WE_B0, WE_B1, WE_B2, WE_B3: mis_err = 1'b0;
      WE_HLO, WE_HHI:                      mis_err = addr[0];
      WE_WORD:                             mis_err = |addr[1:0];
      default:                             en_err  = 1'b1;
    endcase
    err = range_err | mis_err | en_err;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of single-port dmem between core (r0) and loader (r1)
module dmem_arbiter
  import pegasus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     r0,
  dmem_arbiter_if.slave     r1,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [WORD_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [3:0]        we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic arb_en;
  logic pick1;
  logic gnt0;
  logic gnt1;
  logic req_err;

  dmem_req_check #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_check (
    .we   (we_q),
    .addr (addr_q),
    .err  (req_err)
  );

  always_comb begin
    arb_en = (state_q == IDLE) || (state_q == RESP);
    // r1 wins when alone, or on a tie when r0 was served last.
    pick1  = r1.req && (!r0.req || !last_q);
    gnt0   = arb_en && r0.req && !pick1;
    gnt1   = arb_en && pick1;

    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE, RESP: begin
        if (gnt0 || gnt1) begin
          we_d    = gnt1 ? r1.we    : r0.we;
          addr_d  = gnt1 ? r1.addr  : r0.addr;
          wdata_d = gnt1 ? r1.wdata : r0.wdata;
          last_d  = gnt1;
          owner_d = gnt1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        rdata_d = req_err ? '0 : mem_rdata;
        err_d   = req_err;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= WE_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign r0.gnt    = gnt0;
  assign r1.gnt    = gnt1;
  assign r0.rvalid = (state_q == RESP) && !owner_q;
  assign r1.rvalid = (state_q == RESP) && owner_q;
  assign r0.rdata  = rdata_q;
  assign r1.rdata  = rdata_q;
  assign r0.err    = err_q;
  assign r1.err    = err_q;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = ((state_q == ACCESS) && !req_err) ? we_q : WE_NONE;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter with a behavioural dmem
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.AW(32)) u_r0 ();
  dmem_arbiter_if #(.AW(32)) u_r1 ();

  dmem_arbiter #(.DEPTH(256), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0        (u_r0),
    .r1        (u_r1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  typedef struct {
    int          port;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int port, input logic req, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      u_r0.req = req; u_r0.we = we; u_r0.addr = addr; u_r0.wdata = wdata;
    end else begin
      u_r1.req = req; u_r1.we = we; u_r1.addr = addr; u_r1.wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the arbiter idle; returns likewise.
  task automatic do_access(input string name, input int port, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    set_req(port, 1'b1, we, addr, wdata);
    while (!got && n < 8) begin
      @(negedge clk);
      if ((port == 0) ? u_r0.gnt : u_r1.gnt) got = 1'b1;
      else begin step(); n++; end
    end
    chk({name, "_gnt"}, 32'(got), 32'd1);
    if (!got) begin
      set_req(port, 1'b0, 4'b0, 32'h0, 32'h0);
      step();
      return;
    end
    chk({name, "_other_gnt"}, 32'((port == 0) ? u_r1.gnt : u_r0.gnt), 32'd0);
    step();
    set_req(port, 1'b0, 4'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk({name, "_mem_we"}, 32'(mem_we), exp_err ? 32'd0 : 32'(we));
    chk({name, "_mem_addr"}, mem_addr, addr);
    step();
    @(negedge clk);
    chk({name, "_rvalid"}, 32'((port == 0) ? u_r0.rvalid : u_r1.rvalid), 32'd1);
    chk({name, "_other_rvalid"}, 32'((port == 0) ? u_r1.rvalid : u_r0.rvalid), 32'd0);
    chk({name, "_rdata"}, (port == 0) ? u_r0.rdata : u_r1.rdata, exp_rdata);
    chk({name, "_err"}, 32'((port == 0) ? u_r0.err : u_r1.err), 32'(exp_err));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]   = 32'hDEADBEEF;
    mem[8]   = 32'h11223344;
    mem[255] = 32'hCAFEF00D;
    set_req(0, 1'b0, 4'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'b0, 32'h0, 32'h0);

    vecs[0]  = '{0, 4'b0000, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1, 4'b0100, 32'h20,  32'hAAAAAAAA, 32'h11223344, 1'b0};
    vecs[2]  = '{0, 4'b0000, 32'h20,  32'h0,        32'h11AA3344, 1'b0};
    vecs[3]  = '{0, 4'b1111, 32'h22,  32'h12345678, 32'h0,        1'b1};
    vecs[4]  = '{0, 4'b0000, 32'h20,  32'h0,        32'h11AA3344, 1'b0};
    vecs[5]  = '{1, 4'b0000, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{0, 4'b0000, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1, 4'b0011, 32'h11,  32'h12341234, 32'h0,        1'b1};
    vecs[8]  = '{1, 4'b0101, 32'h10,  32'h12341234, 32'h0,        1'b1};
    vecs[9]  = '{0, 4'b1100, 32'h12,  32'h55665566, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{0, 4'b0000, 32'h13,  32'h0,        32'h5566BEEF, 1'b0};
    vecs[11] = '{1, 4'b1000, 32'h3FD, 32'h77777777, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{1, 4'b0000, 32'h3FC, 32'h0,        32'h77FEF00D, 1'b0};

    // Reset values
    step(); step();
    @(negedge clk);
    chk("rst_gnt0", 32'(u_r0.gnt), 32'd0);
    chk("rst_rvalid0", 32'(u_r0.rvalid), 32'd0);
    chk("rst_rvalid1", 32'(u_r1.rvalid), 32'd0);
    chk("rst_err", 32'(u_r0.err), 32'd0);
    chk("rst_rdata", u_r1.rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    step();
    reset = 1'b1;

    // Tie after reset: r0, r1, r0 strictly alternate
    set_req(0, 1'b1, 4'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 4'b0, 32'h3FC, 32'h0);
    @(negedge clk);
    chk("tie_t0_gnt0", 32'(u_r0.gnt), 32'd1);
    chk("tie_t0_gnt1", 32'(u_r1.gnt), 32'd0);
    step();
    u_r0.req = 1'b0;
    @(negedge clk);
    chk("tie_t1_gnt1", 32'(u_r1.gnt), 32'd0);
    step();
    @(negedge clk);
    chk("tie_t2_rvalid0", 32'(u_r0.rvalid), 32'd1);
    chk("tie_t2_rdata0", u_r0.rdata, 32'hDEADBEEF);
    chk("tie_t2_gnt1", 32'(u_r1.gnt), 32'd1);
    step();
    u_r0.req = 1'b1;
    @(negedge clk);
    chk("tie_t3_mem_addr", mem_addr, 32'h3FC);
    step();
    @(negedge clk);
    chk("tie_t4_rvalid1", 32'(u_r1.rvalid), 32'd1);
    chk("tie_t4_rvalid0", 32'(u_r0.rvalid), 32'd0);
    chk("tie_t4_rdata1", u_r1.rdata, 32'hCAFEF00D);
    chk("tie_t4_gnt0", 32'(u_r0.gnt), 32'd1);
    chk("tie_t4_gnt1", 32'(u_r1.gnt), 32'd0);
    step();
    u_r0.req = 1'b0;
    u_r1.req = 1'b0;
    step();
    @(negedge clk);
    chk("tie_t6_rvalid0", 32'(u_r0.rvalid), 32'd1);
    chk("tie_t6_rdata0", u_r0.rdata, 32'hDEADBEEF);
    step();

    for (int i = 0; i < 13; i++)
      do_access($sformatf("v%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    chk("mem_misaligned_untouched", mem[8], 32'h11AA3344);

    // Reset asserted during the ACCESS cycle of a write
    set_req(0, 1'b1, 4'b1111, 32'h30, 32'h99999999);
    @(negedge clk);
    chk("mid_gnt", 32'(u_r0.gnt), 32'd1);
    step();
    set_req(0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid_access_we", 32'(mem_we), 32'hF);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
    chk("mid_rst_rvalid0", 32'(u_r0.rvalid), 32'd0);
    step();
    reset = 1'b1;
    chk("mid_no_write", mem[12], 32'h0);
    do_access("post_rst_read", 0, 4'b0000, 32'h30, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (`dmem`) between two requesters: port 0, the core load/store path, and port 1, the program loader/debug host that fills or inspects memory. Requests are arbitrated round-robin and issued to memory one at a time. Each access completes with a one-cycle response pulse. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- `DEPTH`, 256: memory depth in 32-bit words; valid byte addresses are 0 to DEPTH*4-1.
- `AW`, 32: address width.

Ports (i = 0, 1):
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low.
- `ri_req`  in  1  request valid; held until `ri_gnt`.
- `ri_we`  in  4  byte write enables; 0 means read.
- `ri_addr`  in  AW  byte address.
- `ri_wdata`  in  32  write data, already lane-replicated by the requester.
- `ri_gnt`  out  1  request accepted this cycle (combinational).
- `ri_rvalid`  out  1  one-cycle response pulse.
- `ri_rdata`  out  32  read data; valid only with `ri_rvalid`.
- `ri_err`  out  1  access rejected; valid only with `ri_rvalid`.
- `mem_addr`  out  AW  address to dmem.
- `mem_wdata`  out  32  write data to dmem.
- `mem_we`  out  4  byte write enables to dmem.
- `mem_rdata`  in  32  dmem combinational read data.

## Operation
- State machine has three states: IDLE, ACCESS and RESP.
- **IDLE:** if any `ri_req` is high, choose one requester:
  - If only one requests, it wins.
  - If both request, the port not equal to `last` wins.
  - Assert the winner's `gnt`, latch its `we`, `addr` and `wdata` plus the port id, set `last` to the winner, and go to ACCESS.
- **ACCESS:** drive `mem_addr` and `mem_wdata` from the latched request.
  - `mem_we` is the latched `we` unless the request is in error; in that case `mem_we` is 0.
  - Capture `mem_rdata` into the response register (0 if error), then go to RESP.
- **RESP:** pulse the owner's `rvalid`, with `rdata` and `err` from registers.
  - Arbitration in RESP works exactly as in IDLE. A grant goes straight to ACCESS; otherwise go to IDLE.
- **Error rule**, evaluated on the latched request:
  - Out of range: `addr >= DEPTH*4`.
  - Misaligned halfword write: `we` is 0011 or 1100 and `addr[0]` is 1.
  - Misaligned word write: `we` is 1111 and `addr[1:0]` is not 0.
  - Illegal enables: `we` is not one of 0000, 0001, 0010, 0100, 1000, 0011, 1100 or 1111.
  - Reads are never misaligned; they return the whole word and the requester extracts the byte or halfword.
- Outside ACCESS, `mem_we` is 0. `mem_addr` and `mem_wdata` hold their last latched values.
- The non-owner's `rvalid` is always 0. Both `gnt` lines are never high together.

## Timing
- Request accepted (gnt) at cycle T; memory write or read sampled at the end of T+1; `rvalid` at T+2.
- Peak throughput is one access per 2 cycles, using back-to-back grants from RESP.
- A requester holding `req` high without a grant is served within 4 cycles of its first eligible IDLE/RESP cycle. Round-robin guarantees no starvation.
- A request is ignored if `req` drops before `gnt`. `req` may stay high after `gnt` to request again; it is treated as a new request.
- Reset (asserted asynchronously) sets:
  - state to IDLE and `last` to 1, so port 0 wins the first tie;
  - all `gnt`, `rvalid`, `err` and `mem_we` to 0;
  - `rdata`, `mem_addr` and `mem_wdata` to 0.
- Reset asserted in ACCESS aborts the access; a write whose enable edge has not yet occurred is not performed.
- Deassertion takes effect at the next clock edge. The design has a single clock domain.

## Structure
- Shared package `pegasus_pkg`:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - byte-enable constants (WE_NONE, WE_B0..WE_B3, WE_HLO, WE_HHI, WE_WORD);
  - word-size constant 32.
- One sub-module, `dmem_req_check`: combinational error detection taking `we`, `addr` and `DEPTH`, producing `err`.
- Everything else is flat in `dmem_arbiter`.

## Test plan
- Single read: memory word 0x10 holds 0xDEADBEEF; r0 reads 0x10 → `r0_gnt` at T, `r0_rvalid` at T+2 with 0xDEADBEEF, `err`=0, `mem_we` stays 0.
- Tie after reset: r0 and r1 both request at T → r0 granted at T, r1 granted at T+2 (RESP). Both requesting again → r0 granted at T+4, so grants strictly alternate.
- Byte write: r1 writes `we`=0100 to 0x20 with data 0xAAAAAAAA over a word holding 0x11223344 → a subsequent read returns 0x11AA3344.
- Misaligned word write: `we`=1111 to 0x22 → `mem_we` stays 0, `r0_rvalid`=1 with `err`=1 and `rdata`=0, memory unchanged.
- Out of range: DEPTH=256, read from 0x400 → `err`=1. Read from 0x3FC → `err`=0.
- Reset mid-access: assert `reset` low during ACCESS of a write → no write occurs, outputs are 0 immediately, and the next request after deassertion is served from IDLE.
